typed_fifo_src: RTL and testbench
=================================

# typed_fifo_src

Type-parameterized first-word-fall-through FIFO that sits directly upstream of the type-parameterized consumer cell in the parameter/type-port test bench. It buffers elements of a caller-chosen type `ELEM_T` and presents them to the consumer under a valid/ready handshake. It exercises the same mix of value parameter, header localparam and type parameter, with the type overridden by name at instantiation.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `AW`, localparam in the header parameter list, equal to `$clog2(DEPTH)`: pointer index width; cannot be overridden.
- `ELEM_T`, type parameter, default `logic [7:0]`: element type; any fixed-size packed or unpacked type.

Ports:
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: producer offers `in_data`.
- `in_ready` out 1: FIFO accepts this cycle.
- `in_data` in `ELEM_T`: element to enqueue.
- `out_valid` out 1: head element available.
- `out_ready` in 1: consumer takes the head this cycle.
- `out_data` out `ELEM_T`: head element.
- `count` out AW+1: current occupancy, range 0..DEPTH.

## Operation
- Storage: array `ELEM_T mem[DEPTH]`, plus AW+1-bit `wr_ptr` and `rd_ptr`.
  - Index is `ptr[AW-1:0]`.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- Push occurs when `in_valid && in_ready`. It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Pop occurs when `out_valid && out_ready`. It increments `rd_ptr`.
- Outputs are combinational from state:
  - `in_ready = !full`
  - `out_valid = !empty`
  - `out_data = mem[rd_ptr]`
  - `count = wr_ptr - rd_ptr`, evaluated modulo 2^(AW+1).
- Pointers wrap naturally at 2^(AW+1); there is no explicit wrap logic.
- Simultaneous push and pop, neither full nor empty: both occur and `count` is unchanged.
- Full with pop this cycle: `in_ready` is still 0, so there is no push. There is no same-cycle bypass of freed space.
- Empty with push this cycle: `out_valid` is still 0. The element becomes visible the next cycle, with no write-to-read bypass.
- `out_data` is undefined/stale while `out_valid` is 0. The consumer must ignore it.
- `in_data` is ignored when no push occurs. `mem` contents are not reset.
- Producer protocol: `in_valid` stays high and `in_data` stays stable until accepted. A violation is not detected; whatever is present on the push cycle is stored.

## Timing
- Reset (`rst_n` low, asynchronous): `wr_ptr = rd_ptr = 0`. The outputs therefore take these values immediately and hold them while reset is asserted:
  - `in_ready = 1`
  - `out_valid = 0`
  - `count = 0`
- Reset deassertion is synchronized externally; the block assumes release away from the clock edge.
- Reset mid-operation discards all queued elements. The first push after release appears at the head one cycle later.
- Latency from push to `out_valid` is 1 cycle.
- Latency from pop to `in_ready` rising (from full) is 1 cycle.
- Throughput is one element per cycle sustained while 0 < `count` < DEPTH.
- `count` changes only on rising edges, by +1 (push only), -1 (pop only) or 0.

## Configuration
- `TYPED_FIFO_STATS_EN` defined:
  - Adds output `max_count` [AW:0], a registered high-watermark of `count`.
  - `max_count` resets to 0 and updates on the edge after `count` exceeds it.
  - Adds a sticky 1-bit output `push_when_full`, reset to 0. It sets on any cycle with `in_valid && !in_ready`.
- Not defined: both ports and their logic are absent. Port list and behaviour are otherwise identical.

## Test plan
- Reset, then idle, with DEPTH=4 and `ELEM_T` = `logic [7:0]` -> `in_ready`=1, `out_valid`=0, `count`=0. These hold while `rst_n` is low, including when it is asserted between edges.
- Push 8'hA1..8'hA4 back-to-back with `out_ready`=0 -> `count` reaches 4 and `in_ready`=0 after the 4th edge. A 5th offer (8'hA5) is held off. Then drain with `out_ready`=1 -> outputs A1, A2, A3, A4 on consecutive cycles, `count` returns to 0, and A5 is accepted the cycle after the first pop.
- Continuous push and pop of 0..19 with `out_ready`=1 -> each value appears on `out_data` one cycle after its push. `count` stays at 1, and the pointers wrap at least twice without loss or reordering.
- Full plus simultaneous offer and pop -> no push that cycle, `count` goes 4 to 3, and the offered value is accepted next cycle.
- `ELEM_T` overridden to a 40-bit packed struct {`logic [31:0]` a; `logic [7:0]` b} by named parameter override, with DEPTH=8 -> {32'hDEADBEEF, 8'h5A} passes through intact. Assert `rst_n` with 3 entries queued -> `out_valid` drops immediately and `count`=0.
- With `TYPED_FIFO_STATS_EN` defined: fill to 3, drain, then offer with `in_valid`=1 while full -> `max_count`=3 after the fill. After a later fill to 4 and the offer while full, `max_count`=4 and `push_when_full`=1. Both clear on reset.

Source files
------------

// File: rtl/typed_fifo_src.sv
// First-word-fall-through FIFO over a caller-chosen element type ELEM_T.
// Optional statistics outputs (max_count, push_when_full) are built only when TYPED_FIFO_STATS_EN is defined.
module typed_fifo_src #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  parameter type ELEM_T = logic [7:0]
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  ELEM_T       in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output ELEM_T       out_data,
  output logic [AW:0] count
`ifdef TYPED_FIFO_STATS_EN
  ,
  output logic [AW:0] max_count,
  output logic        push_when_full
`endif
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  ELEM_T       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // The extra pointer MSB tells full apart from empty when the low bits match.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign count     = wr_ptr - rd_ptr;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is deliberately not reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

`ifdef TYPED_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_count      <= '0;
      push_when_full <= 1'b0;
    end else begin
      if (count > max_count)   max_count      <= count;
      if (in_valid && !in_ready) push_when_full <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_typed_fifo_src.sv
// Self-checking bench for typed_fifo_src: byte FIFO against a queue model, plus a struct-typed DEPTH=8 instance.
// Build with TYPED_FIFO_STATS_EN defined to also check the statistics outputs.
module tb_typed_fifo_src;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  b;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;

  logic       s_rst_n = 1'b0;
  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  pair_t      s_in_data = '0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  pair_t      s_out_data;
  logic [3:0] s_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_q[$];

`ifdef TYPED_FIFO_STATS_EN
  logic [2:0] max_count;
  logic       push_when_full;
  logic [3:0] s_max_count;
  logic       s_push_when_full;
  int         model_max = 0;
  logic       model_pwf = 1'b0;
`endif

  always #5 clk = ~clk;

  typed_fifo_src #(.DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
`ifdef TYPED_FIFO_STATS_EN
    , .max_count(max_count), .push_when_full(push_when_full)
`endif
  );

  typed_fifo_src #(.DEPTH(8), .ELEM_T(pair_t)) u_dut_struct (
    .clk(clk), .rst_n(s_rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
`ifdef TYPED_FIFO_STATS_EN
    , .max_count(s_max_count), .push_when_full(s_push_when_full)
`endif
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() < 4));
    checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    checkOutput("count", 64'(count), 64'(model_q.size()));
    if (model_q.size() > 0) checkOutput("out_data", 64'(out_data), 64'(model_q[0]));
`ifdef TYPED_FIFO_STATS_EN
    checkOutput("max_count", 64'(max_count), 64'(model_max));
    checkOutput("push_when_full", 64'(push_when_full), 64'(model_pwf));
`endif
  endtask

  // One clock cycle: drive at the falling edge, check settled outputs, then advance the queue model at the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    checkModel();
    do_push = v && (model_q.size() < 4);
    do_pop  = r && (model_q.size() > 0);
`ifdef TYPED_FIFO_STATS_EN
    if (model_q.size() > model_max) model_max = model_q.size();
    if (v && model_q.size() == 4) model_pwf = 1'b1;
`endif
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic resetModel();
    model_q.delete();
`ifdef TYPED_FIFO_STATS_EN
    model_max = 0;
    model_pwf = 1'b0;
`endif
  endtask

  initial begin
    #3;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_count", 64'(count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    s_rst_n = 1'b1;
    resetModel();

    applyStimulus(1'b0, 8'h00, 1'b0);

    // Fill to full, offer a fifth, then drain while it is still offered.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA1 + 8'(i), 1'b0);
    #1;
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_head", 64'(out_data), 64'hA1);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("held_off_count", 64'(count), 64'd4);
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("first_pop_count", 64'(count), 64'd3);
    checkOutput("first_pop_head", 64'(out_data), 64'hA2);
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("a5_accepted_count", 64'(count), 64'd3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drained_count", 64'(count), 64'd0);

    // Streaming push and pop: occupancy stays at one while pointers wrap.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1);
      checkOutput("stream_count", 64'(count), 64'd1);
      checkOutput("stream_head", 64'(out_data), 64'(i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Full with a simultaneous offer and pop: the offer waits one cycle.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("full_pop_count", 64'(count), 64'd3);
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("offer_taken_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 200; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Reset asserted between edges with entries queued.
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_count", 64'(count), 64'd0);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5C, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

`ifdef TYPED_FIFO_STATS_EN
    rst_n = 1'b0;
    #1;
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stats_max3", 64'(max_count), 64'd3);
    checkOutput("stats_pwf0", 64'(push_when_full), 64'd0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0);
    #1;
    checkOutput("stats_max4", 64'(max_count), 64'd4);
    checkOutput("stats_pwf1", 64'(push_when_full), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("stats_max_reset", 64'(max_count), 64'd0);
    checkOutput("stats_pwf_reset", 64'(push_when_full), 64'd0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Struct-typed instance: a 40-bit element passes through intact.
    s_in_valid = 1'b1;
    s_in_data  = '{a: 32'hDEADBEEF, b: 8'h5A};
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    checkOutput("struct_out_valid", 64'(s_out_valid), 64'd1);
    checkOutput("struct_out_data", 64'(s_out_data), 64'h00DEADBEEF5A);
    checkOutput("struct_count1", 64'(s_count), 64'd1);
    s_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_in_data = '{a: 32'(i + 1), b: 8'(i + 16)};
      @(posedge clk);
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    #1;
    checkOutput("struct_count3", 64'(s_count), 64'd3);
    checkOutput("struct_in_ready", 64'(s_in_ready), 64'd1);
    checkOutput("struct_head_kept", 64'(s_out_data), 64'h00DEADBEEF5A);
    s_rst_n = 1'b0;
    #1;
    checkOutput("struct_reset_out_valid", 64'(s_out_valid), 64'd0);
    checkOutput("struct_reset_count", 64'(s_count), 64'd0);
    @(negedge clk);
    s_rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
